// File: rtl/charge_fetch_pkg.sv
// Shared types for the charge fetch sequencer.
// Grid address, charge word, and the 8-cell beat bundle that travels
// from the scatterer read port to the phi solver.
package charge_fetch_pkg;

    localparam int ADDR_W        = 16;
    localparam int CHARGE_W      = 16;
    localparam int CELLS_PER_REQ = 8;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [CHARGE_W-1:0] charge_t;

    typedef struct packed {
        charge_t [1:0][3:0] data;
        addr_t              base;
    } charge_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } fetch_state_t;

endpackage

// File: rtl/charge_beat_fifo.sv
// First-word-fall-through FIFO of charge beats with async reset.
// Ports: push/push_data in, pop in, head out (current front entry),
// count/empty/full status out.
module charge_beat_fifo
    import charge_fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  charge_beat_t             push_data,
    input  logic                     pop,
    output charge_beat_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    charge_beat_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/charge_fetch.sv
// Sweeps the charge grid after a scatter phase: issues 2x4 read requests,
// captures fixed-latency returns in a skid FIFO, streams beats to the solver.
// Ports: start in; valid_req/grid_addr_out to scatterer; charge_in back;
// rho_valid/rho_ready/rho_data/rho_base to solver; busy/done status.
module charge_fetch
    import charge_fetch_pkg::*;
#(
    parameter int NUM_CELLS  = 1024,
    parameter int READ_LAT   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               valid_req,
    output addr_t [1:0][3:0]   grid_addr_out,
    input  charge_t [1:0][3:0] charge_in,
    output logic               rho_valid,
    input  logic               rho_ready,
    output charge_t [1:0][3:0] rho_data,
    output addr_t              rho_base,
    output logic               busy,
    output logic               done
);

    localparam int    CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int    CR_W     = CNT_W + 1;
    localparam int    OUT_W    = $clog2(READ_LAT + 1);
    localparam addr_t LAST_PTR = addr_t'(NUM_CELLS - CELLS_PER_REQ);

    fetch_state_t         state;
    fetch_state_t         state_nx;
    addr_t                req_ptr;
    logic [READ_LAT-1:0]  pipe_v;
    addr_t [READ_LAT-1:0] pipe_base;
    logic [OUT_W-1:0]     outstanding;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic                 issue;
    logic                 can_issue;
    logic [CR_W-1:0]      credit;
    charge_beat_t         push_beat;
    charge_beat_t         head;

    assign push      = pipe_v[READ_LAT-1];
    assign push_beat = '{data: charge_in, base: pipe_base[READ_LAT-1]};
    assign pop       = !fifo_empty && rho_ready;

    // Credit counts the pop of this same cycle as already freed, so a
    // solver that is always ready sees one request per cycle.
    assign credit    = CR_W'(outstanding) + CR_W'(fifo_count) - CR_W'(pop);
    assign can_issue = (credit < CR_W'(FIFO_DEPTH)) && !(fifo_full && !pop);

    assign valid_req = issue;
    assign rho_valid = !fifo_empty;
    assign rho_data  = head.data;
    assign rho_base  = head.base;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nx      = state;
        issue         = 1'b0;
        done          = 1'b0;
        grid_addr_out = '0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                issue = can_issue;
                if (can_issue && req_ptr == LAST_PTR) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (outstanding == '0 && fifo_empty) state_nx = ST_DONE;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (issue) begin
            for (int l = 0; l < 2; l++) begin
                for (int k = 0; k < 4; k++) begin
                    grid_addr_out[l][k] = req_ptr + addr_t'(4 * l + k);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_ptr     <= '0;
            pipe_v      <= '0;
            pipe_base   <= '0;
            outstanding <= '0;
        end else begin
            state <= state_nx;
            // The last request never increments, so a full 2**ADDR_W grid
            // does not wrap the pointer.
            if (state == ST_IDLE && start) begin
                req_ptr <= '0;
            end else if (issue && req_ptr != LAST_PTR) begin
                req_ptr <= req_ptr + addr_t'(CELLS_PER_REQ);
            end
            pipe_v[0]    <= issue;
            pipe_base[0] <= req_ptr;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_base[i] <= pipe_base[i-1];
            end
            if (issue && !push) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (!issue && push) begin
                outstanding <= outstanding - OUT_W'(1);
            end
        end
    end

    charge_beat_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(push_beat),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_charge_fetch.sv
// Bench for charge_fetch: scatterer latency model, beat scoreboard,
// and scenario tasks for sweep, backpressure, reset and latency corners.
`timescale 1ns/1ps
module tb_charge_fetch;
    import charge_fetch_pkg::*;

    localparam int NC      = 1024;
    localparam int RL      = 3;
    localparam int FD      = 8;
    localparam int NB      = NC / 8;
    localparam int NC7     = 256;
    localparam int RL7     = 7;
    localparam int NB7     = NC7 / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               start, valid_req, rho_valid, rho_ready, busy, done;
    addr_t [1:0][3:0]   grid_addr;
    charge_t [1:0][3:0] charge_in, rho_data;
    addr_t              rho_base;

    logic               start7, valid_req7, rho_valid7, rho_ready7, busy7, done7;
    addr_t [1:0][3:0]   grid_addr7;
    charge_t [1:0][3:0] charge_in7, rho_data7;
    addr_t              rho_base7;

    charge_fetch #(.NUM_CELLS(NC), .READ_LAT(RL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .valid_req(valid_req),
        .grid_addr_out(grid_addr), .charge_in(charge_in),
        .rho_valid(rho_valid), .rho_ready(rho_ready), .rho_data(rho_data),
        .rho_base(rho_base), .busy(busy), .done(done)
    );

    charge_fetch #(.NUM_CELLS(NC7), .READ_LAT(RL7), .FIFO_DEPTH(FD)) dut7 (
        .clk(clk), .rst(rst), .start(start7), .valid_req(valid_req7),
        .grid_addr_out(grid_addr7), .charge_in(charge_in7),
        .rho_valid(rho_valid7), .rho_ready(rho_ready7), .rho_data(rho_data7),
        .rho_base(rho_base7), .busy(busy7), .done(done7)
    );

    function automatic charge_t cell_charge(input addr_t a);
        return charge_t'(a) ^ 16'h5A3C;
    endfunction

    // Scatterer read ports: fixed latency, charge is a function of address.
    logic [RL-1:0]              lat_v = '0;
    addr_t [RL-1:0][1:0][3:0]   lat_a;
    logic [RL7-1:0]             lat_v7 = '0;
    addr_t [RL7-1:0][1:0][3:0]  lat_a7;

    always @(posedge clk) begin
        lat_v  <= {lat_v[RL-2:0], valid_req};
        lat_a  <= {lat_a[RL-2:0], grid_addr};
        lat_v7 <= {lat_v7[RL7-2:0], valid_req7};
        lat_a7 <= {lat_a7[RL7-2:0], grid_addr7};
    end

    always_comb begin
        charge_in  = '0;
        charge_in7 = '0;
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < 4; k++) begin
                charge_in[l][k]  = lat_v[RL-1] ?
                    cell_charge(lat_a[RL-1][l][k]) : 16'hDEAD;
                charge_in7[l][k] = lat_v7[RL7-1] ?
                    cell_charge(lat_a7[RL7-1][l][k]) : 16'hDEAD;
            end
        end
    end

    // Reference: beat i carries base 8i and cell charges of 8i..8i+7.
    function automatic int beat_errors(input charge_beat_t q[$], input int n);
        int e = 0;
        if (q.size() != n) e++;
        for (int i = 0; i < q.size() && i < n; i++) begin
            if (q[i].base !== addr_t'(8 * i)) e++;
            for (int l = 0; l < 2; l++) begin
                for (int k = 0; k < 4; k++) begin
                    if (q[i].data[l][k] !== cell_charge(addr_t'(8 * i + 4 * l + k)))
                        e++;
                end
            end
        end
        return e;
    endfunction

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    charge_beat_t got_q[$];
    charge_beat_t got7[$];
    charge_beat_t hold_b;
    logic         hold_v = 1'b0;
    logic         prev_done = 1'b0;
    int vreq_cnt, done_cnt, first_vreq, last_vreq, first_rv;
    int stab_err, ovf_err, busy_err;
    int vreq7, first7, last7, done7_cnt;

    always @(negedge clk) begin
        if (rst) begin
            hold_v    = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (hold_v && (!rho_valid || rho_base !== hold_b.base ||
                           rho_data !== hold_b.data)) stab_err++;
            if (valid_req) begin
                if (vreq_cnt == 0) first_vreq = cyc;
                last_vreq = cyc;
                vreq_cnt++;
            end
            if (rho_valid && first_rv < 0) first_rv = cyc;
            if (rho_valid && rho_ready)
                got_q.push_back('{data: rho_data, base: rho_base});
            if (done) done_cnt++;
            if (prev_done && busy) busy_err++;
            prev_done = done;
            hold_v    = rho_valid && !rho_ready;
            hold_b    = '{data: rho_data, base: rho_base};
            if (dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop) ovf_err++;

            if (valid_req7) begin
                if (vreq7 == 0) first7 = cyc;
                last7 = cyc;
                vreq7++;
            end
            if (rho_valid7 && rho_ready7)
                got7.push_back('{data: rho_data7, base: rho_base7});
            if (done7) done7_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        vreq_cnt = 0; done_cnt = 0; first_vreq = -1; last_vreq = -1;
        first_rv = -1; stab_err = 0; ovf_err = 0; busy_err = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rnd) rho_ready = 1'($urandom_range(0, 1));
            tick();
            if (done_cnt != 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        rho_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks++;
        if ({valid_req, grid_addr, rho_valid, rho_data, rho_base, busy, done} !== '0)
            $display("FAIL reset_outputs got=%h want=0",
                     {valid_req, grid_addr, rho_valid, rho_data, rho_base, busy, done});
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({valid_req, rho_valid, busy, done} !== 4'b0)
            $display("FAIL idle_after_reset got=%b want=0000",
                     {valid_req, rho_valid, busy, done});
        else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        int e;
        clear_mon();
        rho_ready = 1'b1;
        pulse_start();
        run_until_done(2000, 1'b0, ok);
        repeat (3) tick();
        e = beat_errors(got_q, NB);
        n_checks++;
        if (!ok) $display("FAIL basic_done_timeout got=0 want=1");
        else n_pass++;
        n_checks++;
        if (vreq_cnt !== NB) $display("FAIL basic_vreq_count got=%0d want=%0d", vreq_cnt, NB);
        else n_pass++;
        n_checks++;
        if (last_vreq - first_vreq !== NB - 1)
            $display("FAIL basic_vreq_span got=%0d want=%0d", last_vreq - first_vreq, NB - 1);
        else n_pass++;
        n_checks++;
        if (first_rv - first_vreq !== RL + 1)
            $display("FAIL basic_first_latency got=%0d want=%0d", first_rv - first_vreq, RL + 1);
        else n_pass++;
        n_checks++;
        if (e !== 0) $display("FAIL basic_beats errors got=%0d want=0 n=%0d", e, got_q.size());
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL basic_done_count got=%0d want=1", done_cnt);
        else n_pass++;
        n_checks++;
        if (busy_err !== 0) $display("FAIL basic_busy_after_done got=%0d want=0", busy_err);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int e;
        clear_mon();
        rho_ready = 1'b0;
        pulse_start();
        repeat (30) tick();
        n_checks++;
        if (vreq_cnt !== FD) $display("FAIL bp_stall_count got=%0d want=%0d", vreq_cnt, FD);
        else n_pass++;
        n_checks++;
        if (got_q.size() !== 0) $display("FAIL bp_no_pop got=%0d want=0", got_q.size());
        else n_pass++;
        rho_ready = 1'b1;
        run_until_done(2000, 1'b0, ok);
        e = beat_errors(got_q, NB);
        n_checks++;
        if (!ok || e !== 0)
            $display("FAIL bp_beats got_ok=%0d errors=%0d want_ok=1 errors=0", ok, e);
        else n_pass++;
        n_checks++;
        if (vreq_cnt !== NB || stab_err !== 0 || ovf_err !== 0)
            $display("FAIL bp_totals got vreq=%0d stab=%0d ovf=%0d want %0d/0/0",
                     vreq_cnt, stab_err, ovf_err, NB);
        else n_pass++;
    endtask

    task automatic test_random_ready();
        bit ok;
        int e;
        clear_mon();
        pulse_start();
        run_until_done(8000, 1'b1, ok);
        e = beat_errors(got_q, NB);
        n_checks++;
        if (!ok || e !== 0)
            $display("FAIL rnd_beats got_ok=%0d errors=%0d n=%0d want_ok=1 errors=0",
                     ok, e, got_q.size());
        else n_pass++;
        n_checks++;
        if (stab_err !== 0) $display("FAIL rnd_stable got=%0d want=0", stab_err);
        else n_pass++;
        n_checks++;
        if (ovf_err !== 0) $display("FAIL rnd_overflow got=%0d want=0", ovf_err);
        else n_pass++;
    endtask

    task automatic test_start_busy();
        bit ok;
        bit in_drain = 1'b0;
        int e;
        clear_mon();
        rho_ready = 1'b1;
        pulse_start();
        repeat (10) tick();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL sb_busy_fetch got=%b want=1", busy);
        else n_pass++;
        pulse_start();
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (vreq_cnt >= NB) begin
                in_drain = busy;
                break;
            end
        end
        pulse_start();
        run_until_done(2000, 1'b0, ok);
        repeat (20) tick();
        e = beat_errors(got_q, NB);
        n_checks++;
        if (!in_drain) $display("FAIL sb_busy_drain got=0 want=1");
        else n_pass++;
        n_checks++;
        if (!ok || done_cnt !== 1 || e !== 0)
            $display("FAIL sb_single_sweep got ok=%0d done=%0d err=%0d want 1/1/0",
                     ok, done_cnt, e);
        else n_pass++;
        n_checks++;
        if (vreq_cnt !== NB || busy !== 1'b0)
            $display("FAIL sb_no_restart got vreq=%0d busy=%b want %0d/0",
                     vreq_cnt, busy, NB);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit reached = 1'b0;
        int e;
        clear_mon();
        rho_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            tick();
            if (got_q.size() >= 3) begin
                reached = 1'b1;
                break;
            end
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (!reached ||
            {valid_req, grid_addr, rho_valid, rho_data, rho_base, busy, done} !== '0)
            $display("FAIL mid_reset_outputs reached=%0d got=%h want=0", reached,
                     {valid_req, grid_addr, rho_valid, rho_data, rho_base, busy, done});
        else n_pass++;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (done_cnt !== 0) $display("FAIL mid_no_done got=%0d want=0", done_cnt);
        else n_pass++;
        tick();
        clear_mon();
        pulse_start();
        run_until_done(2000, 1'b0, ok);
        repeat (5) tick();
        e = beat_errors(got_q, NB);
        n_checks++;
        if (!ok || e !== 0 || done_cnt !== 1)
            $display("FAIL mid_clean_sweep got ok=%0d err=%0d done=%0d want 1/0/1",
                     ok, e, done_cnt);
        else n_pass++;
    endtask

    task automatic test_min_depth();
        bit ok = 1'b0;
        int e;
        got7.delete();
        vreq7 = 0; first7 = -1; last7 = -1; done7_cnt = 0;
        rho_ready7 = 1'b1;
        start7 = 1'b1;
        tick();
        start7 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (done7_cnt != 0) begin
                ok = 1'b1;
                break;
            end
        end
        e = beat_errors(got7, NB7);
        n_checks++;
        if (!ok || e !== 0)
            $display("FAIL lat7_beats got ok=%0d err=%0d want 1/0", ok, e);
        else n_pass++;
        n_checks++;
        if (vreq7 !== NB7 || last7 - first7 !== NB7 - 1)
            $display("FAIL lat7_sustained got vreq=%0d span=%0d want %0d/%0d",
                     vreq7, last7 - first7, NB7, NB7 - 1);
        else n_pass++;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        rho_ready  = 1'b0;
        start7     = 1'b0;
        rho_ready7 = 1'b0;
        vreq7 = 0; done7_cnt = 0; first7 = -1; last7 = -1;
        clear_mon();
        test_reset();
        test_basic();
        test_backpressure();
        test_random_ready();
        test_start_busy();
        test_reset_mid();
        test_min_depth();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
